// File: rtl/countdown_timer.sv
// Loadable down-counter with IDLE/RUN/DONE control and a done flag held until acknowledged.
// Latency: all outputs registered, one edge per action; load of N>0 expires N edges later.
// Backpressure: no handshake; done is held until done_ack. COUNTDOWN_TIMER_AUTO_RELOAD_EN enables auto-reload with a sticky overrun flag.
module countdown_timer #(
    parameter int W = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         load,
    input  logic [W-1:0] load_val,
    input  logic         enb,
    input  logic         abort,
    input  logic         done_ack,
    output logic [W-1:0] q,
    output logic         busy,
    output logic         done,
    output logic         overrun
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    localparam logic [W-1:0] ONE = W'(1);

    state_t       state_q, state_d;
    logic [W-1:0] q_q, q_d;
    logic [W-1:0] reload_q, reload_d;
    logic         busy_q, busy_d;
    logic         done_q, done_d;
`ifdef COUNTDOWN_TIMER_AUTO_RELOAD_EN
    logic         overrun_q, overrun_d;
`endif

    always_comb begin
        state_d  = state_q;
        q_d      = q_q;
        reload_d = reload_q;
        done_d   = done_q;
`ifdef COUNTDOWN_TIMER_AUTO_RELOAD_EN
        overrun_d = overrun_q;
`endif
        if (abort) begin
            state_d = ST_IDLE;
            q_d     = '0;
            done_d  = 1'b0;
`ifdef COUNTDOWN_TIMER_AUTO_RELOAD_EN
            overrun_d = 1'b0;
`endif
        end else if (load) begin
            reload_d = load_val;
`ifdef COUNTDOWN_TIMER_AUTO_RELOAD_EN
            overrun_d = 1'b0;
`endif
            if (load_val != '0) begin
                state_d = ST_RUN;
                q_d     = load_val;
                done_d  = 1'b0;
            end else begin
                // A zero terminal count expires immediately, even in auto-reload mode.
                state_d = ST_DONE;
                q_d     = '0;
                done_d  = 1'b1;
            end
        end else begin
            case (state_q)
                ST_RUN: begin
`ifdef COUNTDOWN_TIMER_AUTO_RELOAD_EN
                    if (done_ack) begin
                        done_d = 1'b0;
                    end
`endif
                    if (enb) begin
                        if (q_q > ONE) begin
                            q_d = q_q - ONE;
                        end else if (q_q == ONE) begin
`ifdef COUNTDOWN_TIMER_AUTO_RELOAD_EN
                            // Expiry re-asserts done even if acknowledged this same cycle.
                            q_d    = reload_q;
                            done_d = 1'b1;
                            if (done_q && !done_ack) begin
                                overrun_d = 1'b1;
                            end
`else
                            q_d     = '0;
                            done_d  = 1'b1;
                            state_d = ST_DONE;
`endif
                        end
                    end
                end
                ST_DONE: begin
                    if (done_ack) begin
                        state_d = ST_IDLE;
                        done_d  = 1'b0;
                    end
                end
                ST_IDLE: begin
                end
                default: begin
                    state_d = ST_IDLE;
                    q_d     = '0;
                    done_d  = 1'b0;
                end
            endcase
        end
        busy_d = (state_d == ST_RUN);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= ST_IDLE;
            q_q      <= '0;
            reload_q <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            q_q      <= q_d;
            reload_q <= reload_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
        end
    end

`ifdef COUNTDOWN_TIMER_AUTO_RELOAD_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            overrun_q <= 1'b0;
        end else begin
            overrun_q <= overrun_d;
        end
    end
    assign overrun = overrun_q;
`else
    assign overrun = 1'b0;
`endif

    assign q    = q_q;
    assign busy = busy_q;
    assign done = done_q;

endmodule
